// File: rtl/cnt_pkg.sv
// Shared constants, FSM state type and the step function for cnt_arbiter.
package cnt_pkg;

  localparam int CW      = 10;
  localparam int MIN     = -263;
  localparam int MAX     = 269;
  localparam int INV     = -47;
  localparam int UP_STEP = 4;
  localparam int DN_STEP = 10;
  localparam int RST_VAL = 17;

  // Decision points of the step rules, at one bit wider than the count
  localparam logic signed [CW:0] UP_SKIP_AT = (CW+1)'(INV - UP_STEP);
  localparam logic signed [CW:0] UP_SAT_GT  = (CW+1)'(MAX - UP_STEP);
  localparam logic signed [CW:0] DN_SKIP_AT = (CW+1)'(INV + DN_STEP);
  localparam logic signed [CW:0] DN_SAT_LT  = (CW+1)'(MIN + DN_STEP);
  localparam logic signed [CW:0] UP_ONE     = (CW+1)'(UP_STEP);
  localparam logic signed [CW:0] DN_ONE     = (CW+1)'(DN_STEP);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic signed [CW-1:0] val;
    logic                 sat;
  } step_t;

  // One step from cnt in the given direction; hops over INV, holds at the limits.
  function automatic step_t next_cnt(input logic signed [CW-1:0] cnt, input logic up);
    logic signed [CW:0] wide;
    logic signed [CW:0] res;
    step_t              s;
    wide  = {cnt[CW-1], cnt};
    res   = wide;
    s.sat = 1'b0;
    if (up) begin
      if (wide == UP_SKIP_AT)     res = wide + UP_ONE + UP_ONE;
      else if (wide > UP_SAT_GT)  s.sat = 1'b1;
      else                        res = wide + UP_ONE;
    end else begin
      if (wide == DN_SKIP_AT)     res = wide - DN_ONE - DN_ONE;
      else if (wide < DN_SAT_LT)  s.sat = 1'b1;
      else                        res = wide - DN_ONE;
    end
    s.val = CW'(res);
    return s;
  endfunction

endpackage

// File: rtl/cnt_core.sv
// Counter register: applies one step per enabled cycle, flags held steps.
module cnt_core
  import cnt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  output logic signed [CW-1:0] cnt,
  output logic                 sat
);

  step_t nxt;

  assign nxt = next_cnt(cnt, mode);

  // Count register and the registered saturation pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CW'(RST_VAL);
      sat <= 1'b0;
    end else begin
      sat <= en & nxt.sat;
      if (en) cnt <= nxt.val;
    end
  end

endmodule

// File: rtl/cnt_arbiter.sv
// Round-robin arbiter granting bursts of counter steps to two requesters.
// Handshake: req[i] is a level; gnt[i] stays high for the whole burst and the
// burst continues only while req[i] stays high; dropping req[i] aborts it
// with no further step and no done pulse.
module cnt_arbiter
  import cnt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [1:0]           dir,
  input  logic [2:0]           len0,
  input  logic [2:0]           len1,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic                 sat,
  output logic signed [CW-1:0] cnt,
  output state_t               fsm_state
);

  state_t     state, state_nx;
  logic       owner, owner_nx;
  logic       ptr, ptr_nx;
  logic       mode_q, mode_nx;
  logic [2:0] remaining, rem_nx;
  logic [1:0] done_nx;
  logic       step_en;

  // State, ownership, pointer, remaining count and done register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      mode_q    <= 1'b0;
      remaining <= 3'd0;
      done      <= 2'b00;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      ptr       <= ptr_nx;
      mode_q    <= mode_nx;
      remaining <= rem_nx;
      done      <= done_nx;
    end
  end

  // Arbitration in IDLE, stepping and burst termination in BURST
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    mode_nx  = mode_q;
    rem_nx   = remaining;
    done_nx  = 2'b00;
    step_en  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nx = (req == 2'b11) ? ptr : req[1];
          mode_nx  = dir[owner_nx];
          rem_nx   = owner_nx ? len1 : len0;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (!req[owner]) begin
          state_nx = IDLE;
          ptr_nx   = ~owner;
        end else begin
          step_en = 1'b1;
          if (remaining == 3'd0) begin
            done_nx[owner] = 1'b1;
            state_nx       = IDLE;
            ptr_nx         = ~owner;
          end else begin
            rem_nx = remaining - 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign gnt       = (state == BURST) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign fsm_state = state;

  cnt_core u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (step_en),
    .mode (mode_q),
    .cnt  (cnt),
    .sat  (sat)
  );

endmodule

// File: tb/tb_cnt_arbiter.sv
// Bench for cnt_arbiter: vector table, directed corner sequences, random run.
module tb_cnt_arbiter;
  import cnt_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req, dir;
  logic [2:0]           len0, len1;
  logic [1:0]           gnt, done;
  logic                 sat;
  logic signed [CW-1:0] cnt;
  state_t               fsm_state;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_cnt, m_who, m_left, m_ptr;
  bit m_busy, m_up, m_sat;
  bit [1:0] m_done;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] dir;
    logic [2:0] len0;
    logic [2:0] len1;
    int         e_cnt;
    logic [1:0] e_gnt;
    logic [1:0] e_done;
    logic       e_sat;
  } vec_t;

  vec_t tbl[13];

  cnt_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dir       (dir),
    .len0      (len0),
    .len1      (len1),
    .gnt       (gnt),
    .done      (done),
    .sat       (sat),
    .cnt       (cnt),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // Step: move by the step size, hop once more if that lands on INV,
  // and refuse the move if it would leave [MIN, MAX].
  function automatic int model_move(input int c, input bit up, output bit s);
    int n;
    s = 1'b0;
    n = up ? c + UP_STEP : c - DN_STEP;
    if (n == INV) n = up ? n + UP_STEP : n - DN_STEP;
    if (n > MAX || n < MIN) begin
      s = 1'b1;
      n = c;
    end
    return n;
  endfunction

  task automatic model_step();
    bit s;
    if (rst === 1'b1) begin
      m_cnt = RST_VAL; m_busy = 0; m_ptr = 0; m_done = 0; m_sat = 0;
      m_who = 0; m_left = 0;
      return;
    end
    m_done = 0;
    m_sat  = 0;
    if (!m_busy) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_who = m_ptr;
        else              m_who = req[1] ? 1 : 0;
        m_up   = dir[m_who];
        m_left = (m_who == 1) ? int'(len1) + 1 : int'(len0) + 1;
        m_busy = 1;
      end
    end else if (!req[m_who]) begin
      m_busy = 0;
      m_ptr  = 1 - m_who;
    end else begin
      m_cnt  = model_move(m_cnt, m_up, s);
      m_sat  = s;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done[m_who] = 1'b1;
        m_busy = 0;
        m_ptr  = 1 - m_who;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic tick_chk();
    tick();
    chk("cnt",  int'(cnt),  m_cnt);
    chk("gnt",  int'(gnt),  m_busy ? (1 << m_who) : 0);
    chk("done", int'(done), int'(m_done));
    chk("sat",  int'(sat),  int'(m_sat));
  endtask

  task automatic one_step(input bit up);
    req = 2'b01; dir = {1'b0, up}; len0 = 3'd0;
    tick_chk();
    tick_chk();
    req = 2'b00;
    tick_chk();
  endtask

  task automatic drive_to(input int target);
    for (int k = 0; k < 400 && m_cnt != target; k++) one_step(m_cnt < target);
    chk("drive_to", int'(cnt), target);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00;
    tick_chk();
    tick_chk();
    rst = 1'b0;
  endtask

  initial begin
    int saved;
    rst = 1'b1; req = 2'b00; dir = 2'b00; len0 = 3'd0; len1 = 3'd0;

    // reset, a 3-step up burst for requester 0, then contention after reset
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 17, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 17, 2'b00, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 2'b01, 3'd2, 3'd0, 17, 2'b01, 2'b00, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 2'b01, 3'd2, 3'd0, 21, 2'b01, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 2'b00, 3'd0, 3'd0, 25, 2'b01, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 2'b00, 3'd0, 3'd0, 29, 2'b00, 2'b01, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 29, 2'b00, 2'b00, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 17, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 2'b11, 3'd0, 3'd0, 17, 2'b01, 2'b00, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 2'b11, 3'd0, 3'd0, 21, 2'b00, 2'b01, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 2'b11, 3'd0, 3'd0, 21, 2'b10, 2'b00, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 2'b11, 3'd0, 3'd0, 25, 2'b00, 2'b10, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 25, 2'b00, 2'b00, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; dir = tbl[i].dir;
      len0 = tbl[i].len0; len1 = tbl[i].len1;
      tick();
      chk($sformatf("tbl%0d_cnt", i),  int'(cnt),  tbl[i].e_cnt);
      chk($sformatf("tbl%0d_gnt", i),  int'(gnt),  int'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_sat", i),  int'(sat),  int'(tbl[i].e_sat));
    end

    // hop over INV in both directions
    drive_to(-37);
    one_step(1'b0);
    chk("skip_dn", int'(cnt), -57);
    drive_to(-51);
    one_step(1'b1);
    chk("skip_up", int'(cnt), -43);

    // upper limit reached by long up bursts from reset
    do_reset();
    for (int b = 0; b < 12 && m_cnt < MAX; b++) begin
      req = 2'b01; dir = 2'b01; len0 = 3'd7;
      tick_chk();
      for (int j = 0; j < 12 && m_busy; j++) tick_chk();
      req = 2'b00;
      tick_chk();
    end
    chk("top", int'(cnt), 269);
    req = 2'b01; dir = 2'b01; len0 = 3'd0;
    tick_chk();
    tick_chk();
    chk("sat_hi", int'(sat), 1);
    chk("hold_hi", int'(cnt), 269);
    req = 2'b00;
    tick_chk();

    // lower limit
    drive_to(-247);
    one_step(1'b0);
    chk("bottom", int'(cnt), -257);
    req = 2'b01; dir = 2'b00; len0 = 3'd0;
    tick_chk();
    tick_chk();
    chk("sat_lo", int'(sat), 1);
    chk("hold_lo", int'(cnt), -257);
    req = 2'b00;
    tick_chk();

    // abort requester 1 after two steps
    req = 2'b10; dir = 2'b00; len1 = 3'd7;
    tick_chk();
    tick_chk();
    tick_chk();
    req = 2'b00;
    saved = m_cnt;
    tick_chk();
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_done", int'(done), 0);
    tick_chk();
    chk("abort_hold", int'(cnt), saved);

    // reset in the middle of a burst
    req = 2'b01; dir = 2'b01; len0 = 3'd7;
    tick_chk();
    tick_chk();
    rst = 1'b1;
    tick_chk();
    chk("rst_cnt", int'(cnt), 17);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0; req = 2'b00;
    tick_chk();

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      dir  = 2'($urandom_range(0, 3));
      len0 = 3'($urandom_range(0, 7));
      len1 = 3'($urandom_range(0, 7));
      tick_chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
